// File: rtl/race_game_ctrl_pkg.sv
// Shared definitions for the race game controller.
// Contents: FSM state encoding, winner encoding, BCD digit constants and a
// helper that tests a two-digit BCD value for 00.
package race_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DONE  = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_PLAYER = 2'b01,
        WIN_PC     = 2'b10,
        WIN_DRAW   = 2'b11
    } winner_e;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic bcd2_is_zero(input logic [3:0] tens, input logic [3:0] ones);
        return (tens == BCD_ZERO) && (ones == BCD_ZERO);
    endfunction

endpackage

// File: rtl/race_game_ctrl_if.sv
// Signal bundle between the keyboard decode side and the race controller,
// including the status outputs consumed by the HEX/LED display drivers.
// master: keyboard/test side (drives start and keys, observes status)
// slave : race_game_ctrl (observes start and keys, drives status)
//
// Handshake: key_valid is a single-cycle strobe with key_correct qualifying
// it in the same cycle. There is no ready/backpressure: a strobe is consumed
// or ignored in the cycle it is presented. start is a level; only its rising
// edge matters.
interface race_game_ctrl_if;
    import race_pkg::*;

    logic               start;
    logic               key_valid;
    logic               key_correct;
    logic [STATE_W-1:0] state;
    logic [1:0]         ready_cnt;
    logic [3:0]         p_q0;
    logic [3:0]         p_q1;
    logic [3:0]         pc_q0;
    logic [3:0]         pc_q1;
    logic               locked;
    logic               ended;
    logic [1:0]         winner;

    modport master (
        output start, key_valid, key_correct,
        input  state, ready_cnt, p_q0, p_q1, pc_q0, pc_q1, locked, ended, winner
    );

    modport slave (
        input  start, key_valid, key_correct,
        output state, ready_cnt, p_q0, p_q1, pc_q0, pc_q1, locked, ended, winner
    );

endinterface

// File: rtl/race_game_ctrl_bcd2_down_counter.sv
// Two-digit BCD down-counter with synchronous load.
// Ports: clk, resetn (async active-low), load/load_val (load wins over dec),
// dec (decrement by one), q0/q1 (ones/tens digit), zero (value is 00).
// Decrementing 00 holds at 00; a ones digit of 0 borrows from the tens.
module bcd2_down_counter
    import race_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic       zero
);

    logic [3:0] q0_q, q0_d;
    logic [3:0] q1_q, q1_d;

    always_comb begin
        q0_d = q0_q;
        q1_d = q1_q;
        if (load) begin
            q1_d = load_val[7:4];
            q0_d = load_val[3:0];
        end else if (dec) begin
            if (q0_q != BCD_ZERO) begin
                q0_d = q0_q - 4'd1;
            end else if (q1_q != BCD_ZERO) begin
                q0_d = BCD_NINE;
                q1_d = q1_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q0_q <= RESET_VAL[3:0];
            q1_q <= RESET_VAL[7:4];
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    assign q0   = q0_q;
    assign q1   = q1_q;
    assign zero = bcd2_is_zero(q1_q, q0_q);

endmodule

// File: rtl/race_game_ctrl.sv
// Race round sequencer: player vs PC, each with a BCD score down-counter.
// Ports: clk, resetn (async active-low), game (slave side of
// race_game_ctrl_if: start/key inputs, state/counter/winner status outputs).
// Flow: IDLE -> READY (tick countdown) -> PLAY (player keys and paced PC
// decrements) -> DONE (winner held until the next start edge).
module race_game_ctrl
    import race_pkg::*;
#(
    parameter int TICK_DIV      = 50000000,
    parameter int START_TENS    = 3,
    parameter int START_ONES    = 2,
    parameter int READY_TICKS   = 3,
    parameter int PC_TICKS      = 1,
    parameter int PENALTY_TICKS = 2
) (
    input  logic              clk,
    input  logic              resetn,
    race_game_ctrl_if.slave   game
);

    localparam int TW  = $clog2(TICK_DIV + 1);
    localparam int PCW = $clog2(PC_TICKS + 1);
    localparam int PW  = $clog2(PENALTY_TICKS + 1);

    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  TICK_ONE   = TW'(1);
    localparam logic [PCW-1:0] PC_LAST    = PCW'(PC_TICKS - 1);
    localparam logic [PCW-1:0] PC_ONE     = PCW'(1);
    localparam logic [PW-1:0]  PEN_LOAD   = PW'(PENALTY_TICKS);
    localparam logic [PW-1:0]  PEN_ONE    = PW'(1);
    localparam logic [1:0]     READY_LOAD = 2'(READY_TICKS);
    localparam logic [7:0]     START_VAL  = {4'(START_TENS), 4'(START_ONES)};

    state_e         state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           start_q;
    logic [1:0]     ready_cnt_q, ready_cnt_d;
    logic [PCW-1:0] pc_cnt_q, pc_cnt_d;
    logic [PW-1:0]  pen_cnt_q, pen_cnt_d;
    logic           locked_q, locked_d;
    logic           ended_q, ended_d;
    winner_e        winner_q, winner_d;

    logic tick;
    logic start_rise;
    logic cnt_load;
    logic p_dec, pc_dec;
    logic p_zero, pc_zero;

    // Free-running tick divider, independent of the FSM state.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
    end

    assign start_rise = game.start & ~start_q;

    always_comb begin
        state_d     = state_q;
        ready_cnt_d = ready_cnt_q;
        pc_cnt_d    = pc_cnt_q;
        pen_cnt_d   = pen_cnt_q;
        locked_d    = locked_q;
        ended_d     = ended_q;
        winner_d    = winner_q;
        cnt_load    = 1'b0;
        p_dec       = 1'b0;
        pc_dec      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                locked_d  = 1'b0;
                pen_cnt_d = '0;
                if (start_rise) begin
                    cnt_load    = 1'b1;
                    ready_cnt_d = READY_LOAD;
                    winner_d    = WIN_NONE;
                    ended_d     = 1'b0;
                    state_d     = READY;
                end
            end

            READY: begin
                if (tick) begin
                    if (ready_cnt_q <= 2'd1) begin
                        ready_cnt_d = 2'd0;
                        pc_cnt_d    = '0;
                        state_d     = PLAY;
                    end else begin
                        ready_cnt_d = ready_cnt_q - 2'd1;
                    end
                end
            end

            PLAY: begin
                // End is judged on registered counters; the detecting cycle
                // performs no further decrements.
                if (p_zero || pc_zero) begin
                    state_d   = DONE;
                    ended_d   = 1'b1;
                    locked_d  = 1'b0;
                    pen_cnt_d = '0;
                    if (p_zero && pc_zero) begin
                        winner_d = WIN_DRAW;
                    end else if (p_zero) begin
                        winner_d = WIN_PLAYER;
                    end else begin
                        winner_d = WIN_PC;
                    end
                end else begin
                    // Keys during lockout are dropped so they cannot extend it.
                    if (locked_q) begin
                        if (tick) begin
                            if (pen_cnt_q <= PEN_ONE) begin
                                pen_cnt_d = '0;
                                locked_d  = 1'b0;
                            end else begin
                                pen_cnt_d = pen_cnt_q - PEN_ONE;
                            end
                        end
                    end else if (game.key_valid) begin
                        if (game.key_correct) begin
                            p_dec = 1'b1;
                        end else begin
                            locked_d  = 1'b1;
                            pen_cnt_d = PEN_LOAD;
                        end
                    end

                    if (tick) begin
                        if (pc_cnt_q == PC_LAST) begin
                            pc_dec   = 1'b1;
                            pc_cnt_d = '0;
                        end else begin
                            pc_cnt_d = pc_cnt_q + PC_ONE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            start_q     <= 1'b0;
            ready_cnt_q <= 2'd0;
            pc_cnt_q    <= '0;
            pen_cnt_q   <= '0;
            locked_q    <= 1'b0;
            ended_q     <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            start_q     <= game.start;
            ready_cnt_q <= ready_cnt_d;
            pc_cnt_q    <= pc_cnt_d;
            pen_cnt_q   <= pen_cnt_d;
            locked_q    <= locked_d;
            ended_q     <= ended_d;
            winner_q    <= winner_d;
        end
    end

    bcd2_down_counter #(.RESET_VAL(START_VAL)) u_player_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (START_VAL),
        .dec      (p_dec),
        .q0       (game.p_q0),
        .q1       (game.p_q1),
        .zero     (p_zero)
    );

    bcd2_down_counter #(.RESET_VAL(START_VAL)) u_pc_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (START_VAL),
        .dec      (pc_dec),
        .q0       (game.pc_q0),
        .q1       (game.pc_q1),
        .zero     (pc_zero)
    );

    assign game.state     = state_q;
    assign game.ready_cnt = ready_cnt_q;
    assign game.locked    = locked_q;
    assign game.ended     = ended_q;
    assign game.winner    = winner_q;

endmodule

// File: doc/race_game_ctrl.md
Name: race_game_ctrl

Overview:
Top-level sequencer for one race round between the player and the PC.
- Owns two 2-digit BCD score down-counters, one for the player and one for the PC, both starting at 32.
- Runs a READY countdown, then gates the player's correct-key strobes and a paced PC decrement into the counters.
- Applies a lockout penalty for wrong keys and declares a winner or draw when a counter reaches 00.
- Sits between the keyboard decode logic and the HEX and LED display drivers.

Parameters:
- TICK_DIV, 50000000: clk cycles per game tick (1 Hz at 50 MHz); the bench uses 4.
- START_TENS, 3: BCD tens digit loaded at round start.
- START_ONES, 2: BCD ones digit loaded at round start.
- READY_TICKS, 3: length of the pre-race countdown, in ticks.
- PC_TICKS, 1: ticks between PC decrements.
- PENALTY_TICKS, 2: player lockout after a wrong key, in ticks.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  start request, level; rising edge detected internally
- key_valid  in  1  one-cycle strobe: player pressed a key
- key_correct  in  1  qualifies key_valid; 1 = correct key
- state  out  3  current FSM state (package encoding)
- ready_cnt  out  2  ticks remaining in READY
- p_q0  out  4  player ones digit, BCD
- p_q1  out  4  player tens digit, BCD
- pc_q0  out  4  PC ones digit, BCD
- pc_q1  out  4  PC tens digit, BCD
- locked  out  1  player is in penalty lockout
- ended  out  1  round finished
- winner  out  2  00 none, 01 player, 10 PC, 11 draw

Behaviour:
- Clock and reset: single clock domain on clk; resetn asynchronous active-low; all other inputs synchronous to clk.
- Reset values:
  - state = IDLE; ready_cnt = 0; locked = 0; ended = 0; winner = 00.
  - Both counters = START_TENS/START_ONES (3,2).
  - Tick divider = 0; start edge register = 0; PC and penalty counters = 0.
- Tick: a one-cycle internal pulse when the divider reaches TICK_DIV-1. The divider then wraps to 0. It free-runs in every state.
- FSM states: IDLE, READY, PLAY, DONE.
- IDLE:
  - A start rising edge loads both counters to 32, sets ready_cnt = READY_TICKS, clears winner and ended, and moves to READY on the next cycle.
  - key_valid is ignored.
- READY:
  - Each tick decrements ready_cnt.
  - A tick seen with ready_cnt == 1 sets ready_cnt to 0 and moves to PLAY.
  - Keys and start are ignored.
- PLAY, player path:
  - key_valid & key_correct & !locked decrements the player counter that cycle.
  - key_valid & !key_correct & !locked sets locked = 1 and loads the penalty counter with PENALTY_TICKS.
  - While locked, each tick decrements the penalty counter; locked clears on the tick that reaches 0.
  - key_valid while locked is ignored, so the lockout is not extended.
- PLAY, PC path:
  - The PC counter decrements on every PC_TICKS-th tick, counted from PLAY entry.
  - The PC pace counter is cleared on entry to PLAY.
- Decrement rule (both counters):
  - Ones digit > 0: ones digit - 1.
  - Ones digit = 0 and tens digit > 0: ones digit = 9, tens digit - 1.
  - 00: hold at 00, with no wrap to 99.
  - Digits stay valid BCD (0..9) at all times.
- End detection:
  - Evaluated in PLAY on the registered counter values, one cycle after a counter reaches 00.
  - Both counters 00 → winner = 11 (draw). This covers a player and PC decrement landing on the same cycle.
  - Only the player counter 00 → winner = 01.
  - Only the PC counter 00 → winner = 10.
  - Any of these moves the FSM to DONE with ended = 1.
  - No decrements occur in the cycle that detects the end or after it.
- DONE:
  - Outputs hold: counters, winner, ended = 1.
  - locked is forced to 0.
  - A start rising edge reloads the counters and goes to READY, the same as from IDLE.
- start edges seen in READY or PLAY are ignored. A held start level never retriggers a round.
- A resetn assertion mid-round returns everything to the reset values immediately, asynchronously.

Decomposition:
- Package race_pkg holds:
  - state encodings (IDLE = 0, READY = 1, PLAY = 2, DONE = 3);
  - winner encodings;
  - BCD constants: BCD_NINE = 4'd9, BCD_ZERO = 4'd0.
- Sub-module bcd2_down_counter, instantiated twice:
  - inputs: clk, resetn, load, load_val[7:0], dec;
  - outputs: q0[3:0], q1[3:0], zero;
  - implements the decrement rule and the hold at 00.
- The tick divider, PC pace counter and penalty counter stay in race_game_ctrl.

Test Plan (TICK_DIV = 4, PC_TICKS = 8, PENALTY_TICKS = 2):
- Reset then one start pulse → READY with ready_cnt = 3, counting down to 0 over 3 ticks (12 clk), then PLAY; both counters read 3,2.
- In PLAY, 32 correct key_valid strobes on consecutive cycles → player digits step 32, 31, 30, 29 … 00; one cycle after 00: DONE, ended = 1, winner = 01; PC still 3,2.
- In PLAY with no keys → PC decrements every 32 clk; after 32 decrements PC = 00, then winner = 10 and ended = 1.
- Both counters at 01, with a correct key and a PC decrement on the same cycle → both 00; next cycle DONE, winner = 11.
- One wrong key, then correct keys on every cycle → locked = 1; counters unchanged for 2 ticks (8 clk); the first correct key after locked clears decrements the player by exactly 1.
- resetn pulsed low mid-PLAY with the player at 1,7 → immediately IDLE, counters 3,2, winner 00; a later start edge restarts READY normally.
